// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - control, sprite ROM and canvas VRAM signals of the sprite blitter
interface sprite_blitter_if #(
  parameter int DW    = 15,
  parameter int NSPR  = 16,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
);
  localparam int IW = $clog2(NSPR);
  localparam int AW = $clog2(NSPR * SPR_W * SPR_H);

  logic          start;
  logic [7:0]    x;
  logic [7:0]    y;
  logic [IW-1:0] sprite_id;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic          we;
  logic [DW-1:0] waddr;
  logic [11:0]   wdata;

  // master: game-logic controller plus the ROM and VRAM around the blitter
  modport master (
    output start, x, y, sprite_id, rom_data,
    input  busy, done, rom_addr, we, waddr, wdata
  );

  // slave: the blitter itself
  modport slave (
    input  start, x, y, sprite_id, rom_data,
    output busy, done, rom_addr, we, waddr, wdata
  );
endinterface

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies one sprite from ROM into canvas VRAM, colour-key transparent; SPRITE_BLITTER_CLIP_EN enables canvas clipping
module sprite_blitter #(
  parameter int          DW    = 15,
  parameter int          H_LEN = 200,
  parameter int          V_LEN = 150,
  parameter int          SPR_W = 16,
  parameter int          SPR_H = 16,
  parameter int          NSPR  = 16,
  parameter logic [11:0] KEY   = 12'hF0F
) (
  input  logic pclk,
  input  logic rstn,
  sprite_blitter_if.slave bus
);
  localparam int IW = $clog2(NSPR);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int PW = CW + RW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic          busy_c;
  logic          done_c;
  logic          accept;
  logic          last_issue;

  logic [7:0]    x_r;
  logic [7:0]    y_r;
  logic [IW-1:0] id_r;
  // raster pixel counter: upper bits are the row, lower bits the column
  logic [PW-1:0] pix_cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic [17:0]   abs_col;
  logic [17:0]   abs_row;
  logic          p_valid;
  logic [DW-1:0] waddr_r;
  logic          write_ok;

  assign row        = pix_cnt[PW-1:CW];
  assign col        = pix_cnt[CW-1:0];
  assign accept     = (state == IDLE) && bus.start;
  assign last_issue = (pix_cnt == PW'(SPR_W * SPR_H - 1));

  // state register
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state and handshake outputs
  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nx = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        busy_c   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // latch the request parameters on acceptance
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      x_r  <= '0;
      y_r  <= '0;
      id_r <= '0;
    end else if (accept) begin
      x_r  <= bus.x;
      y_r  <= bus.y;
      id_r <= bus.sprite_id;
    end
  end

  // raster walk over the sprite, one pixel issued per RUN cycle
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn)               pix_cnt <= '0;
    else if (accept)         pix_cnt <= '0;
    else if (state == RUN)   pix_cnt <= pix_cnt + PW'(1);
  end

  // canvas coordinates of the pixel being issued, wide enough not to wrap
  always_comb begin
    abs_col = 18'(x_r) + 18'(col);
    abs_row = 18'(y_r) + 18'(row);
  end

`ifdef SPRITE_BLITTER_CLIP_EN
  logic p_inr;

  // in-range flag travels with the pixel through the ROM latency stage
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) p_inr <= 1'b0;
    else       p_inr <= (abs_col < 18'(H_LEN)) && (abs_row < 18'(V_LEN));
  end

  assign write_ok = p_valid && p_inr;
`else
  assign write_ok = p_valid;
`endif

  // write address stage, aligned with the one-cycle ROM read latency
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      p_valid <= 1'b0;
      waddr_r <= '0;
    end else begin
      p_valid <= (state == RUN);
      if (state == RUN) waddr_r <= DW'(abs_row * 18'(H_LEN) + abs_col);
    end
  end

  // sprite index and pixel counter concatenate to the ROM address (sizes are powers of two)
  assign bus.rom_addr = {id_r, pix_cnt};
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.waddr    = waddr_r;
  assign bus.we       = write_ok && (bus.rom_data != KEY);
  assign bus.wdata    = p_valid ? bus.rom_data : 12'h000;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter against a raster-order reference model
module tb_sprite_blitter;
  localparam int          DW    = 15;
  localparam int          H_LEN = 200;
  localparam int          V_LEN = 150;
  localparam int          SPR_W = 16;
  localparam int          SPR_H = 16;
  localparam int          NSPR  = 16;
  localparam logic [11:0] KEY   = 12'hF0F;
  localparam int          NPIX  = SPR_W * SPR_H;

  logic pclk = 1'b0;
  logic rstn = 1'b0;

  sprite_blitter_if #(.DW(DW), .NSPR(NSPR), .SPR_W(SPR_W), .SPR_H(SPR_H)) bus ();

  sprite_blitter #(
    .DW(DW), .H_LEN(H_LEN), .V_LEN(V_LEN), .SPR_W(SPR_W),
    .SPR_H(SPR_H), .NSPR(NSPR), .KEY(KEY)
  ) dut (
    .pclk(pclk),
    .rstn(rstn),
    .bus(bus)
  );

  initial forever #5 pclk = ~pclk;

  logic [11:0] rom [NSPR*NPIX];
  always @(posedge pclk) bus.rom_data <= rom[bus.rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  int cap_addr[$], cap_data[$], cap_cyc[$], cap_done[$];
  int exp_addr[$], exp_data[$], exp_cyc[$], exp_done[$];
  int cap_busy_n, cap_busy_first, exp_busy_n;

  task automatic do_reset();
    @(negedge pclk);
    rstn = 1'b0;
    bus.start = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    rstn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic clear_model();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete(); exp_done.delete();
    exp_busy_n = 0;
  endtask

  // a blit accepted at edge t0 writes every non-key (and, when clipping, in-canvas) pixel k in cycle t0+k+2
  task automatic model_blit(input int x, input int y, input int id, input int t0);
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        int  k;
        bit  keep;
        logic [11:0] pix;
        k    = r * SPR_W + c;
        pix  = rom[id * NPIX + k];
        keep = (pix != KEY);
`ifdef SPRITE_BLITTER_CLIP_EN
        if (x + c >= H_LEN || y + r >= V_LEN) keep = 0;
`endif
        if (keep) begin
          exp_addr.push_back(((y + r) * H_LEN + x + c) % (1 << DW));
          exp_data.push_back(int'(pix));
          exp_cyc.push_back(t0 + k + 2);
        end
      end
    end
    exp_done.push_back(t0 + NPIX + 2);
    exp_busy_n += NPIX + 1;
  endtask

  // first blit at edge 0; an optional second start at edge s2 is honoured only once the first has returned to idle
  task automatic model_run(input int x0, input int y0, input int id0,
                           input int s2, input int x2, input int y2, input int id2);
    clear_model();
    model_blit(x0, y0, id0, 0);
    if (s2 > 0 && s2 >= NPIX + 3) model_blit(x2, y2, id2, s2);
  endtask

  task automatic capture(input int x0, input int y0, input int id0,
                         input int s2, input int x2, input int y2, input int id2,
                         input int ncyc);
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete(); cap_done.delete();
    cap_busy_n = 0;
    cap_busy_first = -1;
    @(negedge pclk);
    bus.start     = 1'b1;
    bus.x         = 8'(x0);
    bus.y         = 8'(y0);
    bus.sprite_id = 4'(id0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge pclk);
      if (bus.we) begin
        cap_addr.push_back(int'(bus.waddr));
        cap_data.push_back(int'(bus.wdata));
        cap_cyc.push_back(c);
      end
      if (bus.done) cap_done.push_back(c);
      if (bus.busy) begin
        cap_busy_n++;
        if (cap_busy_first < 0) cap_busy_first = c;
      end
      if (c == s2) begin
        bus.start     = 1'b1;
        bus.x         = 8'(x2);
        bus.y         = 8'(y2);
        bus.sprite_id = 4'(id2);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  function automatic int first_bad_write();
    int n;
    n = (cap_addr.size() > exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      if (i >= cap_addr.size() || i >= exp_addr.size()) return i;
      if (cap_addr[i] != exp_addr[i] || cap_data[i] != exp_data[i] || cap_cyc[i] != exp_cyc[i]) return i;
    end
    return -1;
  endfunction

  function automatic string describe(input int i);
    return $sformatf("idx %0d got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", i,
      (i < cap_addr.size()) ? cap_addr[i] : -1, (i < cap_data.size()) ? cap_data[i] : -1,
      (i < cap_cyc.size()) ? cap_cyc[i] : -1, (i < exp_addr.size()) ? exp_addr[i] : -1,
      (i < exp_data.size()) ? exp_data[i] : -1, (i < exp_cyc.size()) ? exp_cyc[i] : -1);
  endfunction

  task automatic test_reset();
    int bad;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.sprite_id = '0;
    rstn = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b we=%b, want 0 0 0", bus.busy, bus.done, bus.we);
    end
    n_checks++;
    if (bus.waddr !== '0 || bus.wdata !== 12'h000 || bus.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: waddr=%0d wdata=%h rom_addr=%0d, want 0 0 0", bus.waddr, bus.wdata, bus.rom_addr);
    end
    rstn = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge pclk);
      if (bus.busy || bus.we || bus.done) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d active cycles without start, want 0", bad);
    end
  endtask

  task automatic test_opaque();
    int bad;
    do_reset();
    capture(10, 20, 0, 0, 0, 0, 0, NPIX + 4);
    model_run(10, 20, 0, 0, 0, 0, 0);
    n_checks++;
    if (cap_addr.size() != 256) begin
      n_fail++;
      $display("FAIL opaque_count: got %0d writes, want 256", cap_addr.size());
    end
    n_checks++;
    if (cap_addr.size() == 0 || cap_addr[0] != 4010 || cap_addr[cap_addr.size()-1] != 7025) begin
      n_fail++;
      $display("FAIL opaque_ends: got first/last %0d/%0d, want 4010/7025",
               (cap_addr.size() > 0) ? cap_addr[0] : -1,
               (cap_addr.size() > 0) ? cap_addr[cap_addr.size()-1] : -1);
    end
    bad = first_bad_write();
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL opaque_writes: %s", describe(bad));
    end
    n_checks++;
    if (cap_busy_n != 257 || cap_busy_first != 1) begin
      n_fail++;
      $display("FAIL opaque_busy: got %0d cycles from %0d, want 257 from 1", cap_busy_n, cap_busy_first);
    end
    n_checks++;
    if (cap_done.size() != 1 || cap_done[0] != 258) begin
      n_fail++;
      $display("FAIL opaque_done: got %0d pulses first %0d, want 1 at 258",
               cap_done.size(), (cap_done.size() > 0) ? cap_done[0] : -1);
    end
  endtask

  task automatic test_color_key();
    int bad, not_fff, hit0;
    do_reset();
    capture(0, 0, 1, 0, 0, 0, 0, NPIX + 4);
    model_run(0, 0, 1, 0, 0, 0, 0);
    not_fff = 0;
    hit0 = 0;
    foreach (cap_data[i]) begin
      if (cap_data[i] != 12'hFFF) not_fff++;
      if (cap_addr[i] == 0) hit0++;
    end
    n_checks++;
    if (cap_addr.size() != 128) begin
      n_fail++;
      $display("FAIL key_count: got %0d writes, want 128", cap_addr.size());
    end
    n_checks++;
    if (not_fff != 0 || hit0 != 0) begin
      n_fail++;
      $display("FAIL key_content: got %0d non-FFF writes and %0d writes to addr 0, want 0 and 0", not_fff, hit0);
    end
    bad = first_bad_write();
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL key_writes: %s", describe(bad));
    end
  endtask

  task automatic test_start_while_busy();
    int bad;
    do_reset();
    capture(30, 40, 2, 50, 100, 90, 3, NPIX + 4);
    model_run(30, 40, 2, 50, 100, 90, 3);
    bad = first_bad_write();
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL busy_start_writes: %s", describe(bad));
    end
    n_checks++;
    if (cap_done.size() != 1 || cap_done[0] != 258 || cap_busy_n != exp_busy_n) begin
      n_fail++;
      $display("FAIL busy_start_done: got %0d pulses first %0d busy %0d, want 1 at 258 busy %0d",
               cap_done.size(), (cap_done.size() > 0) ? cap_done[0] : -1, cap_busy_n, exp_busy_n);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    do_reset();
    @(negedge pclk);
    bus.start = 1'b1; bus.x = 8'd5; bus.y = 8'd6; bus.sprite_id = 4'd0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge pclk);
      bus.start = 1'b0;
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: we=%b busy=%b done=%b, want 0 0 0", bus.we, bus.busy, bus.done);
    end
    @(negedge pclk);
    @(negedge pclk);
    rstn = 1'b1;
    act = 0;
    repeat (300) begin
      @(negedge pclk);
      if (bus.we || bus.busy || bus.done) act++;
    end
    n_checks++;
    if (act != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d active cycles after release, want 0", act);
    end
  endtask

  task automatic test_clip();
    int bad, want_n;
`ifdef SPRITE_BLITTER_CLIP_EN
    want_n = 100;
`else
    want_n = 256;
`endif
    do_reset();
    capture(190, 140, 0, 0, 0, 0, 0, NPIX + 4);
    model_run(190, 140, 0, 0, 0, 0, 0);
    n_checks++;
    if (cap_addr.size() != want_n) begin
      n_fail++;
      $display("FAIL clip_count: got %0d writes, want %0d", cap_addr.size(), want_n);
    end
    bad = first_bad_write();
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL clip_writes: %s", describe(bad));
    end
    n_checks++;
    if (cap_done.size() != 1 || cap_done[0] != 258) begin
      n_fail++;
      $display("FAIL clip_done: got %0d pulses first %0d, want 1 at 258",
               cap_done.size(), (cap_done.size() > 0) ? cap_done[0] : -1);
    end
  endtask

  task automatic test_random();
    int bad, rx, ry, rid;
    for (int it = 0; it < 3; it++) begin
      rx  = $urandom_range(0, H_LEN - SPR_W);
      ry  = $urandom_range(0, V_LEN - SPR_H);
      rid = $urandom_range(2, NSPR - 1);
      do_reset();
      capture(rx, ry, rid, 0, 0, 0, 0, NPIX + 4);
      model_run(rx, ry, rid, 0, 0, 0, 0);
      bad = first_bad_write();
      n_checks++;
      if (bad != -1) begin
        n_fail++;
        $display("FAIL random_writes x=%0d y=%0d id=%0d: %s", rx, ry, rid, describe(bad));
      end
      n_checks++;
      if (cap_done.size() != 1 || cap_done[0] != 258) begin
        n_fail++;
        $display("FAIL random_done: got %0d pulses first %0d, want 1 at 258",
                 cap_done.size(), (cap_done.size() > 0) ? cap_done[0] : -1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad, x1, y1, x2, y2, id1, id2;
    x1 = $urandom_range(0, H_LEN - SPR_W); y1 = $urandom_range(0, V_LEN - SPR_H);
    x2 = $urandom_range(0, H_LEN - SPR_W); y2 = $urandom_range(0, V_LEN - SPR_H);
    id1 = $urandom_range(0, NSPR - 1);     id2 = $urandom_range(0, NSPR - 1);
    do_reset();
    capture(x1, y1, id1, NPIX + 3, x2, y2, id2, 2 * NPIX + 8);
    model_run(x1, y1, id1, NPIX + 3, x2, y2, id2);
    n_checks++;
    if (cap_done.size() != 2 || cap_done[0] != 258 || cap_done[1] != 517) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d, want 2 at 258,517", cap_done.size(),
               (cap_done.size() > 0) ? cap_done[0] : -1, (cap_done.size() > 1) ? cap_done[1] : -1);
    end
    bad = first_bad_write();
    n_checks++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL b2b_writes: %s", describe(bad));
    end
    n_checks++;
    if (cap_busy_n != exp_busy_n) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0d busy cycles, want %0d", cap_busy_n, exp_busy_n);
    end
  endtask

  initial begin
    for (int i = 0; i < NSPR * NPIX; i++) begin
      if (i < NPIX)          rom[i] = 12'h0F0;
      else if (i < 2 * NPIX) rom[i] = (((i / SPR_W) + i) % 2 == 0) ? KEY : 12'hFFF;
      else                   rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    end
    test_reset();
    test_opaque();
    test_color_key();
    test_start_while_busy();
    test_reset_mid();
    test_clip();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
